// File: rtl/pipelined_complex_div_if.sv
// Operand/result handshake bundle for the sequential complex divider.
// Master drives operands and out_ready; slave returns the quotient.
interface pipelined_complex_div_if #(
    parameter int FRAC = 8
) ();
    localparam int OW = 17 + FRAC;

    logic                 in_valid;
    logic                 in_ready;
    logic signed [7:0]    a;
    logic signed [7:0]    b;
    logic signed [7:0]    c;
    logic signed [7:0]    d;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [OW-1:0] real_out;
    logic signed [OW-1:0] imag_out;
    logic                 div_by_zero;

    modport master (
        output in_valid, a, b, c, d, out_ready,
        input  in_ready, out_valid, real_out, imag_out, div_by_zero
    );

    modport slave (
        input  in_valid, a, b, c, d, out_ready,
        output in_ready, out_valid, real_out, imag_out, div_by_zero
    );
endinterface

// File: rtl/pipelined_complex_div.sv
// Sequential complex divider Q = (a+jb)/(c+jd), signed fixed-point result.
// Both quotient halves share one denominator and divide in lockstep.
module pipelined_complex_div #(
    parameter int FRAC = 8
) (
    input logic clk,
    input logic rst,
    pipelined_complex_div_if.slave io
);
    localparam int OW      = 17 + FRAC;
    localparam int DW      = 16 + FRAC;
    localparam int DIV_CYC = 16 + FRAC;
    localparam int CW      = $clog2(DIV_CYC + 1);

    typedef enum logic [1:0] {IDLE, PREP, DIV, DONE} state_t;

    state_t               state_q, state_d;
    logic signed [7:0]    a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
    logic [15:0]          den_q, den_d;
    logic [15:0]          rem_re_q, rem_re_d, rem_im_q, rem_im_d;
    logic [DW-1:0]        quo_re_q, quo_re_d, quo_im_q, quo_im_d;
    logic                 neg_re_q, neg_re_d, neg_im_q, neg_im_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 out_valid_q, out_valid_d;
    logic signed [OW-1:0] real_q, real_d, imag_q, imag_d;
    logic                 dz_q, dz_d;

    logic signed [15:0]   p_ac, p_bd, p_bc, p_ad, p_cc, p_dd;
    logic signed [16:0]   nre, nim;
    logic [15:0]          den, mag_re, mag_im;
    logic [16+DW-1:0]     st_re, st_im;
    logic signed [OW-1:0] re_abs, im_abs;

    // Remainder stays below den, so 16 bits hold it between steps.
    function automatic logic [16+DW-1:0] div_step(
        input logic [15:0]   rem,
        input logic [DW-1:0] quo,
        input logic [15:0]   dv
    );
        logic [16:0] trial;
        trial = {rem, quo[DW-1]};
        if (trial >= {1'b0, dv})
            return {16'(trial - {1'b0, dv}), quo[DW-2:0], 1'b1};
        return {trial[15:0], quo[DW-2:0], 1'b0};
    endfunction

    assign p_ac   = a_q * c_q;
    assign p_bd   = b_q * d_q;
    assign p_bc   = b_q * c_q;
    assign p_ad   = a_q * d_q;
    assign p_cc   = c_q * c_q;
    assign p_dd   = d_q * d_q;
    assign nre    = 17'(p_ac) + 17'(p_bd);
    assign nim    = 17'(p_bc) - 17'(p_ad);
    assign den    = 16'(p_cc) + 16'(p_dd);
    assign mag_re = nre[16] ? 16'(-nre) : nre[15:0];
    assign mag_im = nim[16] ? 16'(-nim) : nim[15:0];
    assign st_re  = div_step(rem_re_q, quo_re_q, den_q);
    assign st_im  = div_step(rem_im_q, quo_im_q, den_q);
    assign re_abs = OW'(quo_re_q);
    assign im_abs = OW'(quo_im_q);

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        d_d         = d_q;
        den_d       = den_q;
        rem_re_d    = rem_re_q;
        rem_im_d    = rem_im_q;
        quo_re_d    = quo_re_q;
        quo_im_d    = quo_im_q;
        neg_re_d    = neg_re_q;
        neg_im_d    = neg_im_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        real_d      = real_q;
        imag_d      = imag_q;
        dz_d        = dz_q;
        unique case (state_q)
            IDLE: begin
                if (io.in_valid) begin
                    a_d     = io.a;
                    b_d     = io.b;
                    c_d     = io.c;
                    d_d     = io.d;
                    state_d = PREP;
                end
            end
            PREP: begin
                den_d    = den;
                neg_re_d = nre[16];
                neg_im_d = nim[16];
                rem_re_d = '0;
                rem_im_d = '0;
                quo_re_d = {mag_re, {FRAC{1'b0}}};
                quo_im_d = {mag_im, {FRAC{1'b0}}};
                cnt_d    = '0;
                state_d  = DIV;
            end
            DIV: begin
                // Zero denominator is resolved on the first DIV cycle.
                if (den_q == '0) begin
                    real_d      = '0;
                    imag_d      = '0;
                    dz_d        = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else if (cnt_q == CW'(DIV_CYC)) begin
                    real_d      = neg_re_q ? -re_abs : re_abs;
                    imag_d      = neg_im_q ? -im_abs : im_abs;
                    dz_d        = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    {rem_re_d, quo_re_d} = st_re;
                    {rem_im_d, quo_im_d} = st_im;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (io.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            d_q         <= '0;
            den_q       <= '0;
            rem_re_q    <= '0;
            rem_im_q    <= '0;
            quo_re_q    <= '0;
            quo_im_q    <= '0;
            neg_re_q    <= 1'b0;
            neg_im_q    <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            real_q      <= '0;
            imag_q      <= '0;
            dz_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            d_q         <= d_d;
            den_q       <= den_d;
            rem_re_q    <= rem_re_d;
            rem_im_q    <= rem_im_d;
            quo_re_q    <= quo_re_d;
            quo_im_q    <= quo_im_d;
            neg_re_q    <= neg_re_d;
            neg_im_q    <= neg_im_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            real_q      <= real_d;
            imag_q      <= imag_d;
            dz_q        <= dz_d;
        end
    end

    assign io.in_ready    = (state_q == IDLE);
    assign io.out_valid   = out_valid_q;
    assign io.real_out    = real_q;
    assign io.imag_out    = imag_q;
    assign io.div_by_zero = dz_q;
endmodule

// File: tb/tb_pipelined_complex_div.sv
// Randomised and directed checks of the complex divider against an
// integer-arithmetic reference of the quotient formulas.
module tb_pipelined_complex_div;
    localparam int FRAC = 8;
    localparam int OW   = 17 + FRAC;
    localparam int LAT  = 2 + 16 + FRAC;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   cyc;

    pipelined_complex_div_if #(.FRAC(FRAC)) io ();

    pipelined_complex_div #(.FRAC(FRAC)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] a, b, c, d;
        int         re, im;
        bit         dz;
        int         lat;
    } vec_t;

    // Reference: exact rational quotient scaled by 2^FRAC, truncated to zero.
    function automatic void model(input logic signed [7:0] a, b, c, d,
                                  output int re, output int im,
                                  output bit dz);
        int ia, ib, ic, id, nre, nim, den;
        ia  = int'(a);
        ib  = int'(b);
        ic  = int'(c);
        id  = int'(d);
        nre = ia * ic + ib * id;
        nim = ib * ic - ia * id;
        den = ic * ic + id * id;
        dz  = (den == 0);
        re  = dz ? 0 : (nre * (1 << FRAC)) / den;
        im  = dz ? 0 : (nim * (1 << FRAC)) / den;
    endfunction

    task automatic send_and_wait(input logic [7:0] ia, ib, ic, id,
                                 output int lat, output bit to);
        int n;
        @(negedge clk);
        n = 0;
        while (!io.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        io.a = ia;
        io.b = ib;
        io.c = ic;
        io.d = id;
        io.in_valid = 1'b1;
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        io.a = 8'($urandom);
        io.b = 8'($urandom);
        io.c = 8'($urandom);
        io.d = 8'($urandom);
        lat = 0;
        to  = 1'b1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            #1;
            if (io.out_valid) begin
                lat = i;
                to  = 1'b0;
                break;
            end
        end
    endtask

    task automatic accept_result();
        @(negedge clk);
        io.out_ready = 1'b1;
        @(posedge clk);
        #1;
        io.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        io.in_valid = 1'b0;
        io.out_ready = 1'b0;
        io.a = '0;
        io.b = '0;
        io.c = '0;
        io.d = '0;
        #3;
        checks++;
        if (io.out_valid !== 1'b0 || io.real_out !== '0 ||
            io.imag_out !== '0 || io.div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b re=%0d im=%0d dz=%b, want 0s",
                     io.out_valid, io.real_out, io.imag_out, io.div_by_zero);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (io.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", io.in_ready);
        end
    endtask

    task automatic test_directed();
        vec_t v[5] = '{
            '{8'h03, 8'h04, 8'h01, 8'h02, 563, -102, 1'b0, LAT},
            '{8'h01, 8'h00, 8'h00, 8'h01, 0, -256, 1'b0, LAT},
            '{8'h80, 8'h80, 8'h01, 8'h00, -32768, -32768, 1'b0, LAT},
            '{8'h80, 8'h80, 8'h80, 8'h80, 256, 0, 1'b0, LAT},
            '{8'h05, 8'hF9, 8'h00, 8'h00, 0, 0, 1'b1, 2}
        };
        int lat;
        bit to;
        for (int i = 0; i < 5; i++) begin
            send_and_wait(v[i].a, v[i].b, v[i].c, v[i].d, lat, to);
            checks++;
            if (to || lat != v[i].lat) begin
                errors++;
                $display("FAIL dir%0d_latency: got %0d (timeout=%b) want %0d",
                         i, lat, to, v[i].lat);
            end
            checks++;
            if (io.real_out !== OW'(v[i].re) || io.imag_out !== OW'(v[i].im) ||
                io.div_by_zero !== v[i].dz) begin
                errors++;
                $display("FAIL dir%0d_result: got re=%0d im=%0d dz=%b want re=%0d im=%0d dz=%b",
                         i, io.real_out, io.imag_out, io.div_by_zero,
                         v[i].re, v[i].im, v[i].dz);
            end
            accept_result();
            checks++;
            if (io.out_valid !== 1'b0 || io.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL dir%0d_handshake: got v=%b rdy=%b want v=0 rdy=1",
                         i, io.out_valid, io.in_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        bit to;
        send_and_wait(8'd3, 8'd4, 8'd1, 8'd2, lat, to);
        @(negedge clk);
        io.a = 8'd1;
        io.b = 8'd0;
        io.c = 8'd0;
        io.d = 8'd1;
        io.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (io.out_valid !== 1'b1 || io.in_ready !== 1'b0 ||
                io.real_out !== OW'(563) || io.imag_out !== OW'(-102) ||
                io.div_by_zero !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: got v=%b rdy=%b re=%0d im=%0d dz=%b want 1 0 563 -102 0",
                         i, io.out_valid, io.in_ready, io.real_out, io.imag_out,
                         io.div_by_zero);
            end
        end
        accept_result();
        io.in_valid = 1'b0;
        checks++;
        if (io.out_valid !== 1'b0 || io.in_ready !== 1'b1 ||
            io.real_out !== OW'(563)) begin
            errors++;
            $display("FAIL bp_release: got v=%b rdy=%b re=%0d want 0 1 563",
                     io.out_valid, io.in_ready, io.real_out);
        end
        @(posedge clk);
        #1;
        checks++;
        if (io.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_not_queued: got in_ready=%b want 1", io.in_ready);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        bit to;
        bit seen;
        @(negedge clk);
        io.a = 8'd3;
        io.b = 8'd4;
        io.c = 8'd1;
        io.d = 8'd2;
        io.in_valid = 1'b1;
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (io.out_valid !== 1'b0 || io.real_out !== '0 ||
            io.imag_out !== '0 || io.div_by_zero !== 1'b0 ||
            io.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_outputs: got v=%b re=%0d im=%0d dz=%b rdy=%b want 0 0 0 0 1",
                     io.out_valid, io.real_out, io.imag_out, io.div_by_zero,
                     io.in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (io.out_valid) seen = 1'b1;
        end
        checks++;
        if (seen || io.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_no_result: got seen=%b rdy=%b want 0 1",
                     seen, io.in_ready);
        end
        send_and_wait(8'd6, 8'd0, 8'd2, 8'd0, lat, to);
        checks++;
        if (to || lat != LAT || io.real_out !== OW'(768) ||
            io.imag_out !== OW'(0) || io.div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_next_op: got lat=%0d re=%0d im=%0d dz=%b want %0d 768 0 0",
                     lat, io.real_out, io.imag_out, io.div_by_zero, LAT);
        end
        accept_result();
    endtask

    task automatic test_random();
        logic [7:0] ra, rb, rc, rd;
        int lat, er, ei, elat;
        bit to, edz;
        for (int n = 0; n < 60; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 8'($urandom);
            rd = 8'($urandom);
            if ($urandom_range(0, 5) == 0) begin
                rc = '0;
                rd = '0;
            end
            model(ra, rb, rc, rd, er, ei, edz);
            elat = edz ? 2 : LAT;
            send_and_wait(ra, rb, rc, rd, lat, to);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            checks++;
            if (to || lat != elat || io.out_valid !== 1'b1 ||
                io.real_out !== OW'(er) || io.imag_out !== OW'(ei) ||
                io.div_by_zero !== edz) begin
                errors++;
                $display("FAIL rand%0d (%0d,%0d)/(%0d,%0d): got lat=%0d v=%b re=%0d im=%0d dz=%b want lat=%0d re=%0d im=%0d dz=%b",
                         n, $signed(ra), $signed(rb), $signed(rc), $signed(rd),
                         lat, io.out_valid, io.real_out, io.imag_out,
                         io.div_by_zero, elat, er, ei, edz);
            end
            accept_result();
        end
    endtask

    task automatic test_back_to_back();
        int er, ei;
        bit edz;
        int hits[$];
        model(8'sd7, -8'sd3, 8'sd2, 8'sd5, er, ei, edz);
        @(negedge clk);
        io.a = 8'd7;
        io.b = 8'hFD;
        io.c = 8'd2;
        io.d = 8'd5;
        io.in_valid = 1'b1;
        io.out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (io.out_valid) begin
                hits.push_back(cyc);
                checks++;
                if (io.real_out !== OW'(er) || io.imag_out !== OW'(ei) ||
                    io.div_by_zero !== edz) begin
                    errors++;
                    $display("FAIL b2b_result: got re=%0d im=%0d dz=%b want %0d %0d %b",
                             io.real_out, io.imag_out, io.div_by_zero, er, ei, edz);
                end
            end
        end
        io.in_valid = 1'b0;
        io.out_ready = 1'b0;
        checks++;
        if (hits.size() < 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d results want >=3", hits.size());
        end
        for (int i = 1; i < hits.size(); i++) begin
            checks++;
            if (hits[i] - hits[i-1] != LAT + 2) begin
                errors++;
                $display("FAIL b2b_spacing%0d: got %0d want %0d",
                         i, hits[i] - hits[i-1], LAT + 2);
            end
        end
        repeat (40) @(posedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
